// File: rtl/alu_pkg.sv
// Shared op-code and FSM encodings for the sequential ALU and its iterative multiply/divide unit.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_SGE   = 4'd10;
   localparam logic [3:0] OP_SGEU  = 4'd11;
   localparam logic [3:0] OP_MUL   = 4'd12;
   localparam logic [3:0] OP_MULHU = 4'd13;
   localparam logic [3:0] OP_DIVU  = 4'd14;
   localparam logic [3:0] OP_REMU  = 4'd15;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ITER = 1'b1;

   // Ops 12-15 run on the iterative unit; everything else is single-cycle.
   function automatic logic is_iter_op(input logic [3:0] op);
      return op[3] & op[2];
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider, one bit per cycle over a 2*XLEN accumulator.
// done rises XLEN cycles after start and holds until ack; acc = {hi,lo} product or {rem,quo}.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              is_div,
   input  logic              ack,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   output logic              done,
   output logic [2*XLEN-1:0] acc
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN);

   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic              div_q, div_d;
   logic              run_q, run_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_trial;

   assign done = run_q && (cnt_q == CNT_MAX);
   assign acc  = acc_q;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      // Partial remainder shifted left with the next dividend bit, minus divisor.
      div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
      acc_d     = acc_q;
      b_d       = b_q;
      div_d     = div_q;
      run_d     = run_q;
      cnt_d     = cnt_q;
      if (start) begin
         acc_d = {{XLEN{1'b0}}, op_a};
         b_d   = op_b;
         div_d = is_div;
         run_d = 1'b1;
         cnt_d = '0;
      end else if (run_q && !done) begin
         cnt_d = cnt_q + 1'b1;
         if (!div_q) begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
         end else if (!div_trial[XLEN]) begin
            acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
         end else begin
            acc_d = {acc_q[2*XLEN-2:XLEN-1], acc_q[XLEN-2:0], 1'b0};
         end
      end else if (done && ack) begin
         run_d = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         run_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         b_q   <= b_d;
         div_q <= div_d;
         run_q <= run_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops land one edge after accept, mul/div XLEN+1 edges after accept.
// Result register is held while out_valid && !out_ready; in_ready drops while stalled or iterating.
module seq_alu
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] alu_in_1,
   input  logic [XLEN-1:0] alu_in_2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_result,
   output logic            alu_bcond,
   output logic            busy
);

   localparam int SH_W = $clog2(XLEN);

   logic [0:0]        state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic              pend_q, pend_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic              bc_q, bc_d;

   logic              fire;
   logic              out_free;
   logic              md_start;
   logic              md_ack;
   logic              md_done;
   logic [2*XLEN-1:0] md_acc;
   logic [XLEN-1:0]   sc_res;
   logic              sc_bc;
   logic [SH_W-1:0]   sh;

   assign out_free   = !out_valid_q || out_ready;
   assign in_ready   = (state_q == ST_IDLE) && out_free;
   assign fire       = in_valid && in_ready;
   assign md_start   = fire && is_iter_op(alu_op);
   assign out_valid  = out_valid_q;
   assign alu_result = res_q;
   assign alu_bcond  = bc_q;
   assign busy       = (state_q == ST_ITER);
   assign sh         = b_q[SH_W-1:0];

   muldiv_iter #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) u_muldiv (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (md_start),
      .is_div  (alu_op[1]),
      .ack     (md_ack),
      .op_a    (alu_in_1),
      .op_b    (alu_in_2),
      .done    (md_done),
      .acc     (md_acc)
   );

   always_comb begin
      sc_res = '0;
      sc_bc  = 1'b0;
      case (op_q)
         OP_ADD:  begin sc_res = a_q + b_q; sc_bc = (a_q == b_q); end
         OP_SUB:  begin sc_res = a_q - b_q; sc_bc = (a_q != b_q); end
         OP_AND:  sc_res = a_q & b_q;
         OP_OR:   sc_res = a_q | b_q;
         OP_XOR:  sc_res = a_q ^ b_q;
         OP_SLL:  sc_res = a_q << sh;
         OP_SRL:  sc_res = a_q >> sh;
         OP_SRA:  sc_res = $signed(a_q) >>> sh;
         OP_SLT:  begin
            sc_bc  = ($signed(a_q) < $signed(b_q));
            sc_res = {{(XLEN-1){1'b0}}, sc_bc};
         end
         OP_SLTU: begin
            sc_bc  = (a_q < b_q);
            sc_res = {{(XLEN-1){1'b0}}, sc_bc};
         end
         OP_SGE:  sc_bc = ($signed(a_q) >= $signed(b_q));
         OP_SGEU: sc_bc = (a_q >= b_q);
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      pend_d      = pend_q;
      out_valid_d = out_valid_q && !out_ready;
      res_d       = res_q;
      bc_d        = bc_q;
      md_ack      = 1'b0;
      if ((state_q == ST_IDLE) && pend_q && out_free) begin
         pend_d      = 1'b0;
         out_valid_d = 1'b1;
         res_d       = sc_res;
         bc_d        = sc_bc;
      end
      // The final ITER cycle stalls here until the output slot is free.
      if ((state_q == ST_ITER) && md_done && out_free) begin
         md_ack      = 1'b1;
         state_d     = ST_IDLE;
         out_valid_d = 1'b1;
         res_d       = op_q[0] ? md_acc[2*XLEN-1:XLEN] : md_acc[XLEN-1:0];
         bc_d        = 1'b0;
      end
      if (fire) begin
         op_d = alu_op;
         a_d  = alu_in_1;
         b_d  = alu_in_2;
         if (is_iter_op(alu_op)) begin
            state_d = ST_ITER;
         end else begin
            pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         pend_q      <= 1'b0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         bc_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         bc_q        <= bc_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at XLEN=32: inputs driven on falling edges, outputs sampled there too.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] alu_in_1;
   logic [XLEN-1:0] alu_in_2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_result;
   logic            alu_bcond;
   logic            busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_alu #(.XLEN(XLEN)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_op     (alu_op),
      .alu_in_1   (alu_in_1),
      .alu_in_2   (alu_in_2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_result (alu_result),
      .alu_bcond  (alu_bcond),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one op, waits (bounded) for acceptance, then scrambles the inputs.
   task automatic send(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      alu_op   = op;
      alu_in_1 = a;
      alu_in_2 = b;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({tag, " in_ready"}, 32'(in_ready), 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      alu_op   = ~op;
      alu_in_1 = ~a;
      alu_in_2 = ~b;
   endtask

   task automatic single(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] res, input logic bc);
      send(tag, op, a, b);
      chk({tag, " valid_early"}, 32'(out_valid), 0);
      @(negedge clk);
      chk({tag, " valid"}, 32'(out_valid), 1);
      chk({tag, " result"}, alu_result, res);
      chk({tag, " bcond"}, 32'(alu_bcond), 32'(bc));
   endtask

   task automatic iter(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] res);
      int k = 0;
      send(tag, op, a, b);
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk({tag, " busy"}, 32'(busy), 1);
            chk({tag, " in_ready_iter"}, 32'(in_ready), 0);
         end
         if (out_valid) begin
            k = i;
            break;
         end
      end
      chk({tag, " latency"}, 32'(k), XLEN + 1);
      chk({tag, " result"}, alu_result, res);
      chk({tag, " bcond"}, 32'(alu_bcond), 0);
      chk({tag, " busy_after"}, 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      alu_op    = '0;
      alu_in_1  = '0;
      alu_in_2  = '0;
      repeat (2) @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst result", alu_result, 0);
      chk("rst bcond", 32'(alu_bcond), 0);
      chk("rst busy", 32'(busy), 0);
      reset_n = 1'b1;
      #1;
      chk("rst in_ready", 32'(in_ready), 1);

      single("add", OP_ADD, 32'd5, 32'd5, 32'd10, 1'b1);
      single("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1);
      single("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
      single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      single("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
      single("srl", OP_SRL, 32'h8000_0000, 32'd36, 32'h0800_0000, 1'b0);
      single("xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0);
      single("sge", OP_SGE, 32'd3, 32'hFFFF_FFFE, 32'd0, 1'b1);
      single("sgeu", OP_SGEU, 32'd3, 32'hFFFF_FFFE, 32'd0, 1'b0);

      iter("mul", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
      iter("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1);
      iter("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
      iter("remu", OP_REMU, 32'd100, 32'd7, 32'd2);
      iter("divu0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
      iter("remu0", OP_REMU, 32'd9, 32'd0, 32'd9);

      // Back-to-back ADDs with out_ready going 1,0,1.
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      alu_op    = OP_ADD;
      alu_in_1  = 32'd1;
      alu_in_2  = 32'd1;
      @(negedge clk);
      chk("b2b valid0", 32'(out_valid), 0);
      alu_in_1 = 32'd2;
      alu_in_2 = 32'd2;
      @(negedge clk);
      chk("b2b r1 valid", 32'(out_valid), 1);
      chk("b2b r1", alu_result, 32'd2);
      out_ready = 1'b0;
      alu_in_1  = 32'd3;
      alu_in_2  = 32'd3;
      #1;
      chk("b2b stall in_ready", 32'(in_ready), 0);
      @(negedge clk);
      chk("b2b hold valid", 32'(out_valid), 1);
      chk("b2b hold r1", alu_result, 32'd2);
      chk("b2b hold bcond", 32'(alu_bcond), 1);
      chk("b2b hold in_ready", 32'(in_ready), 0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("b2b r2 valid", 32'(out_valid), 1);
      chk("b2b r2", alu_result, 32'd4);
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b r3 valid", 32'(out_valid), 1);
      chk("b2b r3", alu_result, 32'd6);
      @(negedge clk);
      chk("b2b drained", 32'(out_valid), 0);

      // Reset in the middle of an iterative op.
      single("pre_rst add", OP_ADD, 32'd7, 32'd8, 32'd15, 1'b0);
      send("mid_rst mul", OP_MUL, 32'd3, 32'd4);
      repeat (9) @(negedge clk);
      chk("mid_rst busy_before", 32'(busy), 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst out_valid", 32'(out_valid), 0);
      chk("mid_rst busy", 32'(busy), 0);
      chk("mid_rst result", alu_result, 0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("mid_rst no_stale", 32'(seen), 0);
      single("post_rst add", OP_ADD, 32'd7, 32'd8, 32'd15, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width, any even value from 8 to 64.
REQ-002 SHALL have parameter CNT_W, default $clog2(XLEN)+1: iteration counter width.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: an operation is presented.
REQ-006 SHALL have port in_ready, output, 1: the block accepts this cycle.
REQ-007 SHALL have port alu_op, input, 4: operation code (see REQ-013).
REQ-008 SHALL have ports alu_in_1 and alu_in_2, input, XLEN each: operands.
REQ-009 SHALL have port out_valid, output, 1: result registers hold a valid result.
REQ-010 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-011 SHALL have ports alu_result (output, XLEN) and alu_bcond (output, 1): registered result and branch condition.
REQ-012 SHALL have port busy, output, 1: high while an iterative operation runs.

Function
REQ-013 SHALL decode alu_op as follows; "shift" means shift by alu_in_2[log2(XLEN)-1:0]:
- 0 ADD (bcond = in1==in2)
- 1 SUB (bcond = in1!=in2)
- 2 AND, 3 OR, 4 XOR
- 5 SLL, 6 SRL, 7 SRA
- 8 SLT (bcond = signed in1<in2)
- 9 SLTU (bcond = unsigned in1<in2)
- 10 SGE (result 0, bcond = signed in1>=in2)
- 11 SGEU (result 0, bcond = unsigned in1>=in2)
- 12 MUL (low XLEN bits), 13 MULHU (high XLEN bits, unsigned)
- 14 DIVU, 15 REMU
REQ-014 SHALL force bcond to 0 for every op not listed with a bcond in REQ-013.
REQ-015 SHALL compute SLT and SLTU results as a zero-extended 1/0.
REQ-016 SHALL perform an accept ("fire") when in_valid && in_ready at a rising edge.
REQ-017 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-018 SHALL complete ops 0-11 in one cycle: accepted at edge N, result and bcond registered with out_valid=1 at edge N+1.
REQ-019 SHALL sustain one op 0-11 per cycle when out_ready is held high.
REQ-020 SHALL implement FSM states IDLE and ITER:
- IDLE -> ITER on an accepted op 12-15.
- ITER -> IDLE after exactly XLEN iteration cycles, loading the output registers and setting out_valid on that same edge.
REQ-021 SHALL, for ops 12-15, raise out_valid XLEN+1 edges after the accepting edge.
REQ-022 SHALL hold busy=1 and in_ready=0 throughout ITER.
REQ-023 SHALL implement MUL/MULHU as radix-2 shift-add over a 2*XLEN accumulator; SHALL NOT use a combinational multiplier.
REQ-024 SHALL implement DIVU/REMU as restoring division, one quotient bit per cycle.
REQ-025 SHALL, on division by zero, return DIVU = all ones and REMU = alu_in_1, still taking XLEN+1 cycles.
REQ-026 SHALL hold alu_result, alu_bcond and out_valid stable while out_valid && !out_ready.
REQ-027 SHALL clear out_valid on out_valid && out_ready, unless a new result loads on the same edge, in which case out_valid stays 1 with the new value.
REQ-028 SHALL capture operands and op internally at accept; input changes after accept SHALL NOT affect the result.
REQ-029 SHALL never drop or duplicate a result; ITER SHALL NOT leave while out_valid && !out_ready (it stalls in its final cycle).

Reset
REQ-030 SHALL, on reset_n low, immediately and asynchronously set: state=IDLE, counter=0, out_valid=0, alu_result=0, alu_bcond=0, busy=0.
REQ-031 SHALL discard any in-flight iterative operation on reset mid-ITER; no result is produced for it.
REQ-032 SHALL hold in_ready=1 on the first rising edge after reset_n deasserts.

Structure
REQ-033 SHALL place the op-code localparams (OP_ADD..OP_REMU) and the FSM state encoding in shared package alu_pkg.
REQ-034 SHALL implement the iterative multiply/divide datapath (accumulator, counter, done pulse) in sub-module muldiv_iter; seq_alu holds the handshake, FSM and single-cycle datapath.

Verification
REQ-035 ADD 5+5, out_ready=1 -> next cycle result=10, bcond=1; SUB 5-7 -> 0xFFFFFFFE, bcond=1.
REQ-036 SLT 0xFFFFFFFF,1 -> result 1, bcond 1; SLTU with the same operands -> result 0, bcond 0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-037 MUL 0xFFFFFFFF*2 -> out_valid exactly 33 edges after accept, result 0xFFFFFFFE; MULHU on the same operands -> 1.
REQ-038 DIVU 100/7 -> 14 and REMU -> 2; DIVU 9/0 -> 0xFFFFFFFF and REMU 9/0 -> 9.
REQ-039 Back-to-back ADDs with out_ready toggling 1,0,1 -> no lost or duplicated result, output stable while stalled, in_ready low during the stall.
REQ-040 reset_n pulsed low at ITER cycle 10 -> out_valid=0 immediately, no stale result afterwards, next ADD completes normally.
